// File: rtl/sap1_run_ctrl_if.sv
// Bus bundle for the SAP-1 run controller: program-load stream, RAM write port,
// run/step controls, sequencer observation and status.
interface sap1_run_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CYC_W  = 16
);
    // Load stream: a byte transfers on every cycle where ld_valid && ld_ready;
    // ld_data must be stable while ld_valid is high, ld_ready never waits on ld_valid.
    logic              load_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              run_req;
    logic              step_mode;
    logic              step_btn;
    logic [5:0]        ring;
    logic [3:0]        opcode;
    logic              cpu_en;
    logic              seq_rst;
    logic              loaded;
    logic              halted;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [2:0]        dbg_state;

    modport master (
        output load_start, ld_valid, ld_data, run_req, step_mode, step_btn, ring, opcode,
        input  ld_ready, ram_we, ram_addr, ram_wdata, cpu_en, seq_rst, loaded, halted,
               cyc_cnt, dbg_state
    );

    modport slave (
        input  load_start, ld_valid, ld_data, run_req, step_mode, step_btn, ring, opcode,
        output ld_ready, ram_we, ram_addr, ram_wdata, cpu_en, seq_rst, loaded, halted,
               cyc_cnt, dbg_state
    );
endinterface

// File: rtl/sap1_run_ctrl.sv
// SAP-1 run/boot controller: loads program RAM from a byte stream, then gates
// the CPU in free-run or single-step mode until HLT is seen at T4.
module sap1_run_ctrl #(
    parameter int         ADDR_W     = 4,
    parameter int         DATA_W     = 8,
    parameter logic [3:0] HLT_OPCODE = 4'hF,
    parameter int         CYC_W      = 16
) (
    input logic            clk,
    input logic            rst,
    sap1_run_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_STEP_WAIT, S_STEP_EXEC, S_HALT
    } state_t;

    localparam logic [5:0]        RING_T4  = 6'b001000;
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [CYC_W-1:0]  CYC_MAX  = '1;
    localparam logic [CYC_W-1:0]  CYC_ONE  = CYC_W'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [CYC_W-1:0]  cyc_q, cyc_nxt, cyc_inc;
    logic              loaded_q, loaded_nxt;
    logic              step_q;
    logic              step_edge;
    logic              halt_hit;
    logic              accept;

    assign step_edge = bus.step_btn & ~step_q;
    // An exact compare means a non-one-hot ring can never look like T4.
    assign halt_hit  = (bus.ring == RING_T4) && (bus.opcode == HLT_OPCODE);
    assign cyc_inc   = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + CYC_ONE;

    assign bus.ld_ready  = (state == S_LOAD);
    assign accept        = bus.ld_valid & bus.ld_ready;
    assign bus.ram_we    = accept;
    assign bus.ram_addr  = ptr;
    assign bus.ram_wdata = bus.ld_ready ? bus.ld_data : '0;
    assign bus.seq_rst   = (state == S_IDLE) || (state == S_LOAD) || (state == S_CLEAR);
    assign bus.cpu_en    = (state == S_RUN) || (state == S_STEP_EXEC);
    assign bus.halted    = (state == S_HALT);
    assign bus.loaded    = loaded_q;
    assign bus.cyc_cnt   = cyc_q;
    assign bus.dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            cyc_q    <= '0;
            loaded_q <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            cyc_q    <= cyc_nxt;
            loaded_q <= loaded_nxt;
            step_q   <= bus.step_btn;
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        cyc_nxt    = cyc_q;
        loaded_nxt = loaded_q;
        case (state)
            S_IDLE, S_HALT: begin
                if (bus.load_start) begin
                    state_nxt = S_LOAD;
                    ptr_nxt   = '0;
                end else if (bus.run_req) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    ptr_nxt = ptr + PTR_ONE;
                    if (ptr == PTR_LAST) begin
                        loaded_nxt = 1'b1;
                        state_nxt  = S_IDLE;
                    end
                end
            end
            S_CLEAR: begin
                cyc_nxt   = '0;
                state_nxt = bus.step_mode ? S_STEP_WAIT : S_RUN;
            end
            S_RUN: begin
                cyc_nxt = cyc_inc;
                if (halt_hit)           state_nxt = S_HALT;
                else if (bus.step_mode) state_nxt = S_STEP_WAIT;
            end
            // Leaving step mode takes priority, so a coincident edge is dropped.
            S_STEP_WAIT: begin
                if (!bus.step_mode)  state_nxt = S_RUN;
                else if (step_edge)  state_nxt = S_STEP_EXEC;
            end
            S_STEP_EXEC: begin
                cyc_nxt   = cyc_inc;
                state_nxt = halt_hit ? S_HALT : S_STEP_WAIT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_sap1_run_ctrl.sv
// Self-checking bench for sap1_run_ctrl: load, reset mid-load, free-run halt,
// single step, restart from HALT and counter saturation.
module tb_sap1_run_ctrl;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int CYC_W  = 16;
    localparam int SAT_W  = 4;
    localparam int W      = ADDR_W + DATA_W;
    localparam int WORDS  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [W-1:0] exp_q[$];

    sap1_run_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W)) bus ();
    sap1_run_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(SAT_W)) sbus ();

    sap1_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HLT_OPCODE(4'hF), .CYC_W(CYC_W))
        dut (.clk(clk), .rst(rst), .bus(bus));
    sap1_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HLT_OPCODE(4'hF), .CYC_W(SAT_W))
        dut_sat (.clk(clk), .rst(rst), .bus(sbus));

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load_start = 0; bus.ld_valid = 0; bus.ld_data = '0; bus.run_req = 0;
        bus.step_mode = 0; bus.step_btn = 0; bus.ring = '0; bus.opcode = '0;
        sbus.load_start = 0; sbus.ld_valid = 0; sbus.ld_data = '0; sbus.run_req = 0;
        sbus.step_mode = 0; sbus.step_btn = 0; sbus.ring = '0; sbus.opcode = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_data = 8'hA5;
        repeat (2) @(posedge clk);
        #2;
        total++; if (bus.ld_ready !== 1'b0) begin bad++; $display("FAIL rst_ld_ready: got %0b expected 0", bus.ld_ready); end
        total++; if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL rst_ram_we: got %0b expected 0", bus.ram_we); end
        total++; if (bus.ram_addr !== '0) begin bad++; $display("FAIL rst_ram_addr: got %0h expected 0", bus.ram_addr); end
        total++; if (bus.ram_wdata !== '0) begin bad++; $display("FAIL rst_ram_wdata: got %0h expected 0", bus.ram_wdata); end
        total++; if (bus.cpu_en !== 1'b0) begin bad++; $display("FAIL rst_cpu_en: got %0b expected 0", bus.cpu_en); end
        total++; if (bus.seq_rst !== 1'b1) begin bad++; $display("FAIL rst_seq_rst: got %0b expected 1", bus.seq_rst); end
        total++; if ({bus.loaded, bus.halted} !== 2'b00) begin bad++; $display("FAIL rst_status: got %0b expected 00", {bus.loaded, bus.halted}); end
        total++; if (bus.cyc_cnt !== '0) begin bad++; $display("FAIL rst_cyc_cnt: got %0h expected 0", bus.cyc_cnt); end
        bus.ld_valid = 1'b0;
        rst = 1'b0;
        adv();
        @(negedge clk);
        total++; if ({bus.seq_rst, bus.cpu_en, bus.ld_ready} !== 3'b100) begin bad++; $display("FAIL idle_outputs: got %0b expected 100", {bus.seq_rst, bus.cpu_en, bus.ld_ready}); end
        adv();
    endtask

    task automatic test_load(input bit rand_mode, input bit issue_start);
        int sent = 0;
        int pulses = 0;
        int cyc = 0;
        bit v;
        logic [DATA_W-1:0] d;
        exp_q.delete();
        if (issue_start) begin
            bus.load_start = 1'b1;
            adv();
            bus.load_start = 1'b0;
        end
        while (sent < WORDS && cyc < 200) begin
            v = rand_mode ? ($urandom_range(0, 3) != 0) : ((cyc % 3) != 2);
            d = rand_mode ? DATA_W'($urandom) : DATA_W'(sent);
            bus.ld_valid = v;
            bus.ld_data = d;
            if (v) exp_q.push_back({ADDR_W'(sent), d});
            @(negedge clk);
            total++; if (bus.ld_ready !== 1'b1) begin bad++; $display("FAIL load_ready: got %0b expected 1", bus.ld_ready); end
            total++; if (bus.ram_we !== v) begin bad++; $display("FAIL load_we: got %0b expected %0b", bus.ram_we, v); end
            if (bus.ram_we === 1'b1) begin
                pulses++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL load_write: got %0h expected none", {bus.ram_addr, bus.ram_wdata});
                end else begin
                    if ({bus.ram_addr, bus.ram_wdata} !== exp_q[0]) begin bad++; $display("FAIL load_write: got %0h expected %0h", {bus.ram_addr, bus.ram_wdata}, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
            end
            if (v) sent++;
            adv();
            cyc++;
        end
        // A byte offered after the final accept must not be written.
        bus.ld_valid = 1'b1;
        bus.ld_data = 8'h5A;
        @(negedge clk);
        total++; if (pulses != WORDS) begin bad++; $display("FAIL load_pulses: got %0d expected %0d", pulses, WORDS); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL load_leftover: got %0d expected 0", exp_q.size()); end
        total++; if (bus.loaded !== 1'b1) begin bad++; $display("FAIL load_loaded: got %0b expected 1", bus.loaded); end
        total++; if ({bus.ld_ready, bus.ram_we} !== 2'b00) begin bad++; $display("FAIL load_done_ready: got %0b expected 00", {bus.ld_ready, bus.ram_we}); end
        total++; if ({bus.seq_rst, bus.cpu_en} !== 2'b10) begin bad++; $display("FAIL load_done_idle: got %0b expected 10", {bus.seq_rst, bus.cpu_en}); end
        adv();
        bus.ld_valid = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        bus.load_start = 1'b1;
        adv();
        bus.load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data = DATA_W'($urandom);
            @(negedge clk);
            total++; if ({bus.ram_we, bus.ram_addr} !== {1'b1, ADDR_W'(i)}) begin bad++; $display("FAIL midload_addr: got %0h expected %0h", {bus.ram_we, bus.ram_addr}, {1'b1, ADDR_W'(i)}); end
            adv();
        end
        bus.ld_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.ld_ready !== 1'b0) begin bad++; $display("FAIL midload_rst_ready: got %0b expected 0", bus.ld_ready); end
        total++; if (bus.loaded !== 1'b0) begin bad++; $display("FAIL midload_rst_loaded: got %0b expected 0", bus.loaded); end
        total++; if (bus.seq_rst !== 1'b1) begin bad++; $display("FAIL midload_rst_seq: got %0b expected 1", bus.seq_rst); end
        adv();
        rst = 1'b0;
        adv();
        test_load(1'b1, 1'b1);
    endtask

    task automatic test_free_run(input int n_pre, input bit rand_mode);
        logic [5:0] r;
        logic [3:0] op;
        bus.step_mode = 1'b0;
        bus.ring = '0;
        bus.opcode = '0;
        bus.run_req = 1'b1;
        adv();
        bus.run_req = 1'b0;
        @(negedge clk);
        total++; if ({bus.seq_rst, bus.cpu_en} !== 2'b10) begin bad++; $display("FAIL run_clear: got %0b expected 10", {bus.seq_rst, bus.cpu_en}); end
        adv();
        for (int i = 0; i < n_pre; i++) begin
            if (rand_mode) begin
                r = 6'($urandom_range(0, 63));
                op = 4'($urandom_range(0, 15));
                if (r == 6'b001000 && op == 4'hF) op = 4'h0;
            end else begin
                r = 6'(1 << (i % 6));
                op = (i >= 6) ? 4'hF : 4'h0;
            end
            bus.ring = r;
            bus.opcode = op;
            @(negedge clk);
            total++; if ({bus.cpu_en, bus.seq_rst, bus.halted} !== 3'b100) begin bad++; $display("FAIL run_en: got %0b expected 100", {bus.cpu_en, bus.seq_rst, bus.halted}); end
            total++; if (bus.cyc_cnt !== CYC_W'(i)) begin bad++; $display("FAIL run_count: got %0d expected %0d", bus.cyc_cnt, i); end
            adv();
        end
        bus.ring = 6'b001000;
        bus.opcode = 4'hF;
        @(negedge clk);
        total++; if (bus.cpu_en !== 1'b1) begin bad++; $display("FAIL run_t4_en: got %0b expected 1", bus.cpu_en); end
        adv();
        @(negedge clk);
        total++; if ({bus.halted, bus.cpu_en} !== 2'b10) begin bad++; $display("FAIL halt_state: got %0b expected 10", {bus.halted, bus.cpu_en}); end
        total++; if (bus.cyc_cnt !== CYC_W'(n_pre + 1)) begin bad++; $display("FAIL halt_count: got %0d expected %0d", bus.cyc_cnt, n_pre + 1); end
        repeat (3) adv();
        @(negedge clk);
        total++; if ({bus.halted, bus.cyc_cnt} !== {1'b1, CYC_W'(n_pre + 1)}) begin bad++; $display("FAIL halt_hold: got %0h expected %0h", {bus.halted, bus.cyc_cnt}, {1'b1, CYC_W'(n_pre + 1)}); end
        adv();
    endtask

    task automatic test_single_step(input bit rand_mode);
        int holds[3] = '{1, 5, 2};
        int n_press;
        int hold;
        int gap;
        int pulses = 0;
        bit prev_en = 1'b0;
        bus.ring = '0;
        bus.opcode = '0;
        bus.step_btn = 1'b0;
        bus.step_mode = 1'b1;
        bus.run_req = 1'b1;
        adv();
        bus.run_req = 1'b0;
        adv();
        @(negedge clk);
        total++; if ({bus.cpu_en, bus.halted, bus.seq_rst} !== 3'b000) begin bad++; $display("FAIL step_wait: got %0b expected 000", {bus.cpu_en, bus.halted, bus.seq_rst}); end
        total++; if (bus.cyc_cnt !== '0) begin bad++; $display("FAIL step_clear: got %0d expected 0", bus.cyc_cnt); end
        adv();
        n_press = rand_mode ? $urandom_range(2, 6) : 3;
        for (int p = 0; p < n_press; p++) begin
            hold = rand_mode ? $urandom_range(1, 6) : holds[p];
            gap = rand_mode ? $urandom_range(1, 4) : 2;
            for (int c = 0; c < hold + gap; c++) begin
                bus.step_btn = (c < hold);
                bus.ring = 6'($urandom_range(0, 7));
                bus.opcode = 4'($urandom_range(0, 15));
                @(negedge clk);
                if (bus.cpu_en === 1'b1) begin
                    pulses++;
                    total++; if (prev_en) begin bad++; $display("FAIL step_width: got 2+ cycles expected 1"); end
                end
                prev_en = (bus.cpu_en === 1'b1);
                adv();
            end
        end
        bus.step_btn = 1'b0;
        @(negedge clk);
        total++; if (pulses != n_press) begin bad++; $display("FAIL step_pulses: got %0d expected %0d", pulses, n_press); end
        total++; if (bus.cyc_cnt !== CYC_W'(n_press)) begin bad++; $display("FAIL step_count: got %0d expected %0d", bus.cyc_cnt, n_press); end
        adv();
        // Edge and leaving step mode together: free-run resumes, step is dropped.
        bus.ring = '0;
        bus.step_btn = 1'b1;
        bus.step_mode = 1'b0;
        adv();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.step_mode = 1'b1;
            @(negedge clk);
            total++; if ({bus.cpu_en, bus.cyc_cnt} !== {1'b1, CYC_W'(n_press + k)}) begin bad++; $display("FAIL step_to_run: got %0h expected %0h", {bus.cpu_en, bus.cyc_cnt}, {1'b1, CYC_W'(n_press + k)}); end
            adv();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if ({bus.cpu_en, bus.cyc_cnt} !== {1'b0, CYC_W'(n_press + 4)}) begin bad++; $display("FAIL step_held_btn: got %0h expected %0h", {bus.cpu_en, bus.cyc_cnt}, {1'b0, CYC_W'(n_press + 4)}); end
            adv();
        end
        bus.step_btn = 1'b0;
        bus.step_mode = 1'b0;
        adv();
        bus.ring = 6'b001000;
        bus.opcode = 4'hF;
        adv();
        @(negedge clk);
        total++; if ({bus.halted, bus.cyc_cnt} !== {1'b1, CYC_W'(n_press + 5)}) begin bad++; $display("FAIL step_halt: got %0h expected %0h", {bus.halted, bus.cyc_cnt}, {1'b1, CYC_W'(n_press + 5)}); end
        adv();
    endtask

    task automatic test_restart();
        bus.ring = '0;
        bus.opcode = '0;
        bus.step_mode = 1'b0;
        bus.run_req = 1'b1;
        adv();
        bus.run_req = 1'b0;
        adv();
        @(negedge clk);
        total++; if ({bus.halted, bus.cpu_en, bus.cyc_cnt} !== {2'b01, CYC_W'(0)}) begin bad++; $display("FAIL restart_run: got %0h expected %0h", {bus.halted, bus.cpu_en, bus.cyc_cnt}, {2'b01, CYC_W'(0)}); end
        adv();
        bus.ring = 6'b001000;
        bus.opcode = 4'hF;
        adv();
        @(negedge clk);
        total++; if ({bus.halted, bus.cyc_cnt} !== {1'b1, CYC_W'(2)}) begin bad++; $display("FAIL restart_halt: got %0h expected %0h", {bus.halted, bus.cyc_cnt}, {1'b1, CYC_W'(2)}); end
        adv();
        bus.ring = '0;
        bus.load_start = 1'b1;
        bus.run_req = 1'b1;
        adv();
        bus.load_start = 1'b0;
        bus.run_req = 1'b0;
        #1;
        total++; if ({bus.ld_ready, bus.halted, bus.seq_rst} !== 3'b101) begin bad++; $display("FAIL halt_to_load: got %0b expected 101", {bus.ld_ready, bus.halted, bus.seq_rst}); end
        test_load(1'b1, 1'b0);
    endtask

    task automatic test_saturation();
        int lim = (1 << SAT_W) - 1;
        sbus.run_req = 1'b1;
        adv();
        sbus.run_req = 1'b0;
        adv();
        for (int k = 0; k <= 20; k++) begin
            sbus.ring = 6'($urandom_range(0, 7));
            sbus.opcode = 4'($urandom_range(0, 14));
            @(negedge clk);
            total++; if ({sbus.cpu_en, sbus.cyc_cnt} !== {1'b1, SAT_W'((k < lim) ? k : lim)}) begin bad++; $display("FAIL sat_count: got %0h expected %0h", {sbus.cpu_en, sbus.cyc_cnt}, {1'b1, SAT_W'((k < lim) ? k : lim)}); end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_load(1'b0, 1'b1);
        test_reset_mid_load();
        test_free_run(9, 1'b0);
        test_free_run($urandom_range(1, 40), 1'b1);
        test_single_step(1'b0);
        test_restart();
        test_single_step(1'b1);
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sap1_run_ctrl.md
Name: sap1_run_ctrl

Overview:
- Top-level run/boot controller for the SAP-1 core. Sits beside the control sequencer and program RAM.
- Loads the 16x8 program RAM from a valid/ready byte stream, then releases the CPU from reset.
- Gates CPU advance through a clock-enable in free-run or single-step mode.
- Detects the HLT instruction at T4, freezes the CPU, and counts executed T-states.

Parameters:
- ADDR_W, 4, RAM address width; program length is 2^ADDR_W words.
- DATA_W, 8, RAM word width.
- HLT_OPCODE, 4'hF, opcode treated as halt.
- CYC_W, 16, width of the T-state counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  level; request program load.
- ld_valid  in  1  load byte valid.
- ld_data  in  DATA_W  load byte.
- ld_ready  out  1  controller accepts a byte this cycle.
- ram_we  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM write address.
- ram_wdata  out  DATA_W  RAM write data.
- run_req  in  1  level; start or restart execution.
- step_mode  in  1  1 = single-step, 0 = free-run.
- step_btn  in  1  step request; rising edge detected internally.
- ring  in  6  one-hot T-state from the sequencer (T1=6'b000001 .. T6=6'b100000).
- opcode  in  4  current instruction-register opcode.
- cpu_en  out  1  CPU clock enable.
- seq_rst  out  1  reset to sequencer/PC/IR.
- loaded  out  1  full program loaded since last rst.
- halted  out  1  CPU stopped on HLT.
- cyc_cnt  out  CYC_W  T-states executed since last CLEAR.

Behaviour:
- On rst (async): state=IDLE, load pointer=0, step edge register=0, cyc_cnt=0, loaded=0, halted=0, cpu_en=0, seq_rst=1, ld_ready=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - rst mid-LOAD discards the partial load (loaded stays 0). RAM contents already written are not touched.
- States: IDLE, LOAD, CLEAR, RUN, STEP_WAIT, STEP_EXEC, HALT.
- seq_rst=1 in IDLE, LOAD and CLEAR; 0 elsewhere. cpu_en=1 only in RUN and STEP_EXEC.
- IDLE:
  - load_start -> LOAD, pointer=0.
  - else run_req -> CLEAR.
  - Both asserted: load_start wins.
- LOAD:
  - ld_ready=1.
  - ram_we = ld_valid & ld_ready (combinational); ram_addr=pointer; ram_wdata=ld_data.
  - Each accepted byte increments the pointer.
  - Byte accepted at pointer 2^ADDR_W-1: loaded<=1, pointer wraps to 0, ld_ready drops next cycle, -> IDLE.
  - load_start and run_req ignored in LOAD.
- CLEAR: exactly 1 cycle. cyc_cnt<=0, halted<=0. Next state STEP_WAIT if step_mode else RUN.
- RUN:
  - cyc_cnt increments each cycle, saturating at all-ones.
  - step_mode=1 -> STEP_WAIT next cycle.
- STEP_WAIT:
  - step_btn rising edge (registered previous value, 0->1) -> STEP_EXEC.
  - step_mode=0 -> RUN.
  - Edge and step_mode=0 in the same cycle: RUN; the edge is dropped.
- STEP_EXEC: exactly 1 cycle with cpu_en=1 (one T-state), cyc_cnt+1, -> STEP_WAIT. A held step_btn yields one step only.
- Halt detect, in RUN or STEP_EXEC: ring==6'b001000 and opcode==HLT_OPCODE -> HALT next cycle.
  - The detecting cycle still counts.
  - cpu_en=0 from the next cycle.
  - halted=1 while in HALT.
- HALT:
  - load_start -> LOAD (halted cleared).
  - else run_req -> CLEAR (restart from PC=0).
  - cyc_cnt holds.
- Non-one-hot ring: never a halt match, no other effect.
- run_req is level-sensitive. If held high, RUN ends in HALT; a held run_req then restarts via CLEAR the next cycle. Benches pulse it.

Test Plan:
- Load: rst, load_start=1, stream 16 bytes 8'h00..8'h0F with ld_valid stalled every 3rd cycle -> 16 ram_we pulses, addr 0..15 matching data, loaded=1, state IDLE, ld_ready=0 after last byte.
- Reset mid-load: after 5 bytes assert rst -> ld_ready=0, loaded=0, seq_rst=1 immediately. A new load restarts at ram_addr=0.
- Free-run halt: after load, run_req pulse -> 1 cycle seq_rst then cpu_en=1. Drive ring T1..T6 with opcode 4'h0 then T1..T4 with opcode 4'hF -> halted=1 and cpu_en=0 one cycle after T4, cyc_cnt=10.
- Single step: step_mode=1, run_req -> cpu_en=0. Three step_btn pulses (one held 5 cycles) -> exactly 3 single-cycle cpu_en pulses, cyc_cnt=3. Then step_mode=0 -> RUN.
- Restart from HALT: run_req -> CLEAR (cyc_cnt=0, halted=0) -> RUN. load_start and run_req together in HALT -> LOAD.
- Saturation: CYC_W=4, free-run 20 cycles with no HLT -> cyc_cnt stops at 4'hF.
